// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, FSM encoding, CLAIM layout.
// Configuration defaults for source count and per-source trigger mode.
package irq_ctrl_pkg;

   localparam int              N_SRC_DEF     = 6;
   localparam logic [5:0]      EDGE_MASK_DEF = 6'b000100;

   localparam logic [1:0]      OFF_MASK  = 2'd0;
   localparam logic [1:0]      OFF_PEND  = 2'd1;
   localparam logic [1:0]      OFF_CLAIM = 2'd2;
   localparam logic [1:0]      OFF_EOI   = 2'd3;

   localparam int              CLAIM_VLD_BIT = 31;
   localparam int              ID_W          = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      INSVC = 2'd2
   } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit priority encoder, purely combinational (zero latency).
// Returns {vld, id, onehot}; no handshake, no backpressure.
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int W = 6
) (
   input  logic [W-1:0]    req,
   output logic            vld,
   output logic [ID_W-1:0] id,
   output logic [W-1:0]    oh
);

   always_comb begin
      vld = 1'b0;
      id  = '0;
      oh  = '0;
      // Scan high to low so the lowest set bit is the last one written.
      for (int i = W - 1; i >= 0; i--) begin
         if (req[i]) begin
            vld = 1'b1;
            id  = ID_W'(i);
            oh  = W'(1) << i;
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller; hw asserts two edges after irq_in rises, bus writes never stall.
// Define IRQ_CTRL_PREEMPT_EN for nested service (higher-priority claim while in service).
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int               N_SRC     = N_SRC_DEF,
   parameter logic [N_SRC-1:0] EDGE_MASK = EDGE_MASK_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_in,
   input  logic [1:0]       addr,
   input  logic             we,
   input  logic [31:0]      din,
   output logic [31:0]      dout,
   output logic [N_SRC-1:0] hw
);

   logic [N_SRC-1:0] mask_q, mask_d, pend_q, pend_d, isr_q, isr_d;
   logic [N_SRC-1:0] irq_q, hw_q, hw_d;
   state_t           state_q, state_d;

   logic             win_vld, isr_vld;
   logic [ID_W-1:0]  win_id, isr_id;
   logic [N_SRC-1:0] win_oh, isr_oh;

   logic             wr_mask, wr_pend, wr_claim, wr_eoi;
   logic [N_SRC-1:0] set_vec, claim_oh;
   logic             claim_ok, eoi_ok, elig_cur, elig_nxt;
   logic             unused_ok;

   irq_prio_enc #(.W(N_SRC)) u_win_enc (
      .req (pend_q & mask_q),
      .vld (win_vld),
      .id  (win_id),
      .oh  (win_oh)
   );

   irq_prio_enc #(.W(N_SRC)) u_isr_enc (
      .req (isr_q),
      .vld (isr_vld),
      .id  (isr_id),
      .oh  (isr_oh)
   );

   assign unused_ok = ^{din[31:N_SRC], isr_id};

   // Bits at or above the given one-hot position's priority (the bit and all lower indices).
   function automatic logic [N_SRC-1:0] upto(input logic [N_SRC-1:0] oh);
      return oh | (oh - N_SRC'(1));
   endfunction

   function automatic logic eligible(input logic vld, input logic [N_SRC-1:0] oh,
                                     input logic [N_SRC-1:0] isr);
`ifdef IRQ_CTRL_PREEMPT_EN
      return vld && ((isr & upto(oh)) == '0);
`else
      return vld && (isr == '0) && (oh != '0);
`endif
   endfunction

   always_comb begin
      wr_mask  = we && (addr == OFF_MASK);
      wr_pend  = we && (addr == OFF_PEND);
      wr_claim = we && (addr == OFF_CLAIM);
      wr_eoi   = we && (addr == OFF_EOI);

      set_vec  = irq_in & (~EDGE_MASK | ~irq_q);
      // Out-of-range ids shift out of the vector, so they never hit.
      claim_oh = N_SRC'(1) << din[ID_W-1:0];
`ifdef IRQ_CTRL_PREEMPT_EN
      claim_ok = wr_claim && ((claim_oh & pend_q & mask_q) != '0) &&
                 ((state_q == REQ) ||
                  ((state_q == INSVC) && ((isr_q & upto(claim_oh)) == '0)));
`else
      claim_ok = wr_claim && ((claim_oh & pend_q & mask_q) != '0) && (state_q == REQ);
`endif
      eoi_ok   = wr_eoi && isr_vld;

      mask_d = wr_mask ? din[N_SRC-1:0] : mask_q;
      pend_d = (pend_q & ~(wr_pend ? din[N_SRC-1:0] : '0)
                       & ~(claim_ok ? claim_oh : '0)) | set_vec;

      isr_d = isr_q;
      if (claim_ok) isr_d = isr_d | claim_oh;
      if (eoi_ok)   isr_d = isr_d & ~isr_oh;

      elig_cur = eligible(win_vld, win_oh, isr_q);
      elig_nxt = eligible(win_vld, win_oh, isr_d);

      state_d = state_q;
      case (state_q)
         IDLE:    if (elig_nxt) state_d = REQ;
         REQ: begin
            if (claim_ok)       state_d = INSVC;
            else if (!elig_nxt) state_d = IDLE;
         end
         INSVC:   if (eoi_ok && (isr_d == '0)) state_d = elig_nxt ? REQ : IDLE;
         default: state_d = IDLE;
      endcase

      hw_d = ((state_d != IDLE) && elig_nxt) ? win_oh : '0;
   end

   always_comb begin
      dout = '0;
      case (addr)
         OFF_MASK:  dout[N_SRC-1:0] = mask_q;
         OFF_PEND:  dout[N_SRC-1:0] = pend_q;
         OFF_CLAIM: begin
            dout[CLAIM_VLD_BIT] = elig_cur;
            dout[ID_W-1:0]      = elig_cur ? win_id : '0;
         end
         default:   dout = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q  <= '0;
         pend_q  <= '0;
         isr_q   <= '0;
         irq_q   <= '0;
         hw_q    <= '0;
         state_q <= IDLE;
      end else begin
         mask_q  <= mask_d;
         pend_q  <= pend_d;
         isr_q   <= isr_d;
         irq_q   <= irq_in;
         hw_q    <= hw_d;
         state_q <= state_d;
      end
   end

   assign hw = hw_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl; expected values hand-derived, optional nested-service path
// selected by IRQ_CTRL_PREEMPT_EN.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  irq_in;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic [5:0]  hw;

   int checks = 0;
   int errors = 0;

   irq_ctrl dut (
      .clk    (clk),
      .reset  (reset),
      .irq_in (irq_in),
      .addr   (addr),
      .we     (we),
      .din    (din),
      .dout   (dout),
      .hw     (hw)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      addr = a;
      din  = d;
      we   = 1'b1;
      step();
      we   = 1'b0;
      din  = '0;
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(tag, dout, exp);
   endtask

   initial begin
      reset = 1'b1; irq_in = '0; addr = '0; we = 1'b0; din = '0;
      step(); step();
      reset = 1'b0;
      chk("reset_hw", 32'(hw), 32'h0);
      rd("reset_mask", 2'd0, 32'h0);
      rd("reset_pend", 2'd1, 32'h0);
      rd("reset_claim", 2'd2, 32'h0);

      // basic latency: PEND one edge after rise, hw one edge later
      bus_wr(2'd0, 32'h3F);
      rd("mask_rd", 2'd0, 32'h3F);
      irq_in = 6'h01;
      step();
      rd("lat_pend", 2'd1, 32'h01);
      chk("lat_hw_early", 32'(hw), 32'h0);
      step();
      chk("lat_hw", 32'(hw), 32'h01);
      rd("lat_claim", 2'd2, 32'h8000_0000);
      bus_wr(2'd2, 32'd0);
      chk("claim0_hw", 32'(hw), 32'h0);
      rd("claim0_rd", 2'd2, 32'h0);
      irq_in = 6'h00;
      step();
      bus_wr(2'd1, 32'h01);
      rd("w1c_pend", 2'd1, 32'h0);
      bus_wr(2'd3, 32'd0);
      chk("eoi0_hw", 32'(hw), 32'h0);

      // two sources rising together: serviced in priority order
      irq_in = 6'h03;
      step();
      irq_in = 6'h00;
      step();
      chk("dual_hw0", 32'(hw), 32'h01);
      rd("dual_pend", 2'd1, 32'h03);
      bus_wr(2'd2, 32'd0);
      chk("dual_claim_hw", 32'(hw), 32'h0);
      rd("dual_pend2", 2'd1, 32'h02);
      bus_wr(2'd3, 32'd0);
      chk("dual_hw1", 32'(hw), 32'h02);
      rd("dual_claim1", 2'd2, 32'h8000_0001);
      bus_wr(2'd2, 32'd1);
      bus_wr(2'd3, 32'd0);
      chk("dual_end_hw", 32'(hw), 32'h0);
      rd("dual_end_pend", 2'd1, 32'h0);
      rd("dual_end_claim", 2'd2, 32'h0);

      // masked request stays pending, then unmasking raises hw
      bus_wr(2'd0, 32'h3D);
      irq_in = 6'h02;
      step();
      irq_in = 6'h00;
      step(); step();
      rd("masked_pend", 2'd1, 32'h02);
      chk("masked_hw", 32'(hw), 32'h0);
      bus_wr(2'd0, 32'h3F);
      chk("unmask_hw_wr", 32'(hw), 32'h0);
      step();
      chk("unmask_hw", 32'(hw), 32'h02);
      bus_wr(2'd2, 32'd1);
      bus_wr(2'd3, 32'd0);
      chk("unmask_end_hw", 32'(hw), 32'h0);

      // edge source: W1C mid-pulse, no re-trigger while held
      irq_in = 6'h04;
      step();
      step();
      rd("edge_pend", 2'd1, 32'h04);
      chk("edge_hw", 32'(hw), 32'h04);
      bus_wr(2'd1, 32'h04);
      rd("edge_w1c", 2'd1, 32'h0);
      step();
      chk("edge_hw_drop", 32'(hw), 32'h0);
      repeat (6) step();
      rd("edge_held_pend", 2'd1, 32'h0);
      chk("edge_held_hw", 32'(hw), 32'h0);
      irq_in = 6'h00;
      step();

      // level source: W1C while held loses to the set condition
      irq_in = 6'h01;
      step(); step();
      bus_wr(2'd1, 32'h01);
      rd("level_w1c", 2'd1, 32'h01);
      chk("level_hw", 32'(hw), 32'h01);
      irq_in = 6'h00;
      step();
      bus_wr(2'd1, 32'h01);
      step();
      chk("level_end_hw", 32'(hw), 32'h0);
      rd("level_end_pend", 2'd1, 32'h0);

      // illegal claims are ignored
      irq_in = 6'h02;
      step();
      irq_in = 6'h00;
      step();
      bus_wr(2'd2, 32'd7);
      chk("claim7_hw", 32'(hw), 32'h02);
      rd("claim7_pend", 2'd1, 32'h02);
      rd("claim7_claim", 2'd2, 32'h8000_0001);
      bus_wr(2'd2, 32'd0);
      chk("claimnp_hw", 32'(hw), 32'h02);
      rd("claimnp_pend", 2'd1, 32'h02);
      bus_wr(2'd2, 32'd1);
      chk("claim1_hw", 32'(hw), 32'h0);
      rd("claim1_pend", 2'd1, 32'h0);

      // higher-priority request arrives while source 1 is in service
      irq_in = 6'h01;
      step(); step();
`ifdef IRQ_CTRL_PREEMPT_EN
      chk("pre_hw", 32'(hw), 32'h01);
      rd("pre_claim_rd", 2'd2, 32'h8000_0000);
      irq_in = 6'h00;
      bus_wr(2'd2, 32'd0);
      chk("pre_nest_hw", 32'(hw), 32'h0);
      rd("pre_nest_pend", 2'd1, 32'h0);
      bus_wr(2'd3, 32'd0);
      chk("pre_eoi1_hw", 32'(hw), 32'h0);
      irq_in = 6'h04;
      step();
      irq_in = 6'h00;
      step();
      chk("pre_isr1_blocks", 32'(hw), 32'h0);
      rd("pre_isr1_pend", 2'd1, 32'h04);
      bus_wr(2'd3, 32'd0);
      chk("pre_eoi2_hw", 32'(hw), 32'h04);
      bus_wr(2'd2, 32'd2);
      bus_wr(2'd3, 32'd0);
`else
      chk("nopre_hw", 32'(hw), 32'h0);
      rd("nopre_claim_rd", 2'd2, 32'h0);
      bus_wr(2'd2, 32'd0);
      chk("nopre_claim_hw", 32'(hw), 32'h0);
      rd("nopre_claim_pend", 2'd1, 32'h01);
      bus_wr(2'd3, 32'd0);
      chk("nopre_eoi_hw", 32'(hw), 32'h01);
      irq_in = 6'h00;
      bus_wr(2'd2, 32'd0);
      bus_wr(2'd3, 32'd0);
`endif
      chk("nest_end_hw", 32'(hw), 32'h0);
      rd("nest_end_pend", 2'd1, 32'h0);

      // EOI in IDLE ignored; masked request stays pending
      bus_wr(2'd0, 32'h3E);
      irq_in = 6'h01;
      step();
      irq_in = 6'h00;
      step();
      bus_wr(2'd3, 32'd0);
      rd("idle_eoi_pend", 2'd1, 32'h01);
      chk("idle_eoi_hw", 32'(hw), 32'h0);
      rd("idle_eoi_mask", 2'd0, 32'h3E);
      rd("eoi_reg_rd", 2'd3, 32'h0);

      // reset during service clears everything, no EOI needed afterwards
      bus_wr(2'd0, 32'h3F);
      step();
      chk("pre_rst_hw", 32'(hw), 32'h01);
      bus_wr(2'd2, 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_hw", 32'(hw), 32'h0);
      rd("rst_mask", 2'd0, 32'h0);
      rd("rst_pend", 2'd1, 32'h0);
      rd("rst_claim", 2'd2, 32'h0);
      bus_wr(2'd0, 32'h01);
      irq_in = 6'h01;
      step();
      irq_in = 6'h00;
      step();
      chk("post_rst_hw", 32'(hw), 32'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Memory-mapped interrupt controller between the interrupt sources (timer0 IRQ, timer1 IRQ, external interrupt, spares) and the CPU hardware-interrupt lines HW[5:0].
- Latches requests into a pending register, applies a mask and picks the highest-priority request by fixed priority.
- Presents the winner one-hot on hw; tracks in-service state until software writes EOI.
- Sits behind the bridge as a third slave, alongside timer0 and timer1.

Parameters:
N_SRC, 6, number of interrupt sources; equals the HW width.
EDGE_MASK, 6'b000100, per-source mode: 1 = rising-edge triggered, 0 = level triggered. Bit 2 is the external interrupt.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
irq_in  input  N_SRC  raw requests; bit0 = timer0, bit1 = timer1, bit2 = external
addr  input  2  word offset within the block, taken from bus address bits [3:2]
we  input  1  bus write enable, qualified by the bridge decode
din  input  32  bus write data
dout  output  32  bus read data, combinational from addr
hw  output  N_SRC  one-hot interrupt request to the CPU, registered

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset clears MASK, PEND, ISR, the irq_in delay register and hw to 0; state goes to IDLE. Reset mid-service drops everything, with no EOI required.
- Register map (word offset):
  - 0 MASK[5:0]: read/write; 1 = enabled.
  - 1 PEND[5:0]: read; writing 1 to a bit clears it.
  - 2 CLAIM: read returns {valid in bit31, 0s, id[2:0]} of the current winner. A write with din[2:0] = id claims that source.
  - 3 EOI: any write ends service.
- Read-data rules: unused dout bits read 0. Reads have no side effects.
- Pending capture:
  - Edge source: PEND bit set when irq_in = 1 and the previous sampled irq_in = 0.
  - Level source: PEND bit set on every cycle irq_in = 1; a W1C clear only holds once the input drops.
- Priority: lower index wins. winner = lowest set bit of PEND & MASK. It is eligible only if its priority is strictly higher than every ISR bit (see Optional Feature).
- State machine (3 states):
  - IDLE to REQ: when an eligible winner exists.
  - REQ to IDLE: if the winner vanishes (masked or cleared) before claim.
  - REQ to INSVC: on a valid CLAIM write. Clears PEND[id] and sets ISR[id].
  - INSVC to IDLE or REQ: on EOI write. Clears the highest-priority set ISR bit. Next state is REQ if an eligible winner exists, otherwise IDLE.
- hw output:
  - hw <= onehot(winner) when the next state is REQ; otherwise hw <= 0.
  - Latency: irq_in rises at edge t, PEND is set at edge t+1, hw asserts at edge t+2.
- Boundary conditions:
  - CLAIM write with id >= N_SRC, or with PEND[id] & MASK[id] = 0: ignored, no state change.
  - EOI write in IDLE or REQ with ISR = 0: ignored.
  - Source set condition and a W1C or CLAIM clear on the same bit in the same cycle: set wins.
  - MASK write takes effect for winner selection in the following cycle.
  - PEND is unaffected by MASK; masked requests stay pending.

Optional Feature:
IRQ_CTRL_PREEMPT_EN
- Defined: nested service. A pending request of strictly higher priority than the highest ISR bit becomes eligible while in INSVC. hw asserts it and a CLAIM sets a second ISR bit. ISR holds up to N_SRC bits; each EOI pops the highest-priority bit, and the state stays INSVC while ISR != 0.
- Undefined: at most one ISR bit. No winner is eligible while ISR != 0, so hw = 0 throughout INSVC. A CLAIM write in INSVC is ignored.

Decomposition:
- Package irq_ctrl_pkg holds:
  - the register offsets: OFF_MASK = 0, OFF_PEND = 1, OFF_CLAIM = 2, OFF_EOI = 3;
  - the state encoding: IDLE, REQ, INSVC;
  - the CLAIM valid-bit position (31) and the id width (3).
- Sub-module irq_prio_enc: combinational lowest-set-bit encoder producing {valid, id, onehot}. It is instantiated twice: once for the winner over PEND & MASK, once for the highest-priority ISR bit.

Test Plan:
- Reset then MASK = 6'h3F; hold irq_in[0] = 1 from cycle 5 -> PEND[0] = 1 at edge 6, hw = 6'h01 at edge 7, CLAIM reads 0x80000000.
- irq_in[0] and irq_in[1] both rising in the same cycle; claim, EOI, claim, EOI -> hw = 6'h01 first, then 6'h02 after the first EOI, then 0 with state IDLE.
- MASK = 6'h3D; pulse irq_in[1] -> PEND = 6'h02 and hw stays 0. Then write MASK = 6'h3F -> hw = 6'h02 within 2 cycles.
- Edge source 2: hold irq_in[2] high for 10 cycles, W1C PEND bit 2 mid-pulse -> PEND[2] stays 0 and no second request. Level source 0: W1C while held high -> PEND[0] re-sets the next cycle.
- CLAIM id = 7, then CLAIM of a non-pending id -> no change to ISR, PEND or state. EOI in IDLE -> no effect.
- Claim source 1, then raise irq_in[0]:
  - Without IRQ_CTRL_PREEMPT_EN: hw = 0 until EOI.
  - With it: hw = 6'h01 during INSVC; the first EOI after the nested claim clears ISR[0] and leaves ISR[1] = 1.
